axi_default_slave: RTL and testbench
====================================

AXI_DEFAULT_SLAVE -- requirements
Module: axi_default_slave

Interface
REQ-001 The block SHALL have parameter ID_W, default 8, meaning the slave-side transaction ID width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the data width; the strobe width is DATA_W/8.
REQ-004 The block SHALL have parameter LEN_W, default 4, meaning the burst length field width.
REQ-005 Port ACLK, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 Port ARESETn, input, 1 bit: asynchronous, active-low reset.
REQ-007 Write-address ports: S_AWID (in, ID_W), S_AWAddr (in, ADDR_W), S_AWLen (in, LEN_W), S_AWSize (in, 3), S_AWBurst (in, 2), S_AWValid (in, 1), S_AWReady (out, 1).
REQ-008 Write-data ports: S_WData (in, DATA_W), S_WStrb (in, DATA_W/8), S_WLast (in, 1), S_WValid (in, 1), S_WReady (out, 1).
REQ-009 Write-response ports: S_BID (out, ID_W), S_BResp (out, 2), S_BValid (out, 1), S_BReady (in, 1).
REQ-010 Read-address ports: S_ARID (in, ID_W), S_ARAddr (in, ADDR_W), S_ARLen (in, LEN_W), S_ARSize (in, 3), S_ARBurst (in, 2), S_ARValid (in, 1), S_ARReady (out, 1).
REQ-011 Read-data ports: S_RID (out, ID_W), S_RData (out, DATA_W), S_RResp (out, 2), S_RLast (out, 1), S_RValid (out, 1), S_RReady (in, 1).
REQ-012 Status port err_cnt, output, 16 bits: saturating count of completed decode-error transactions.
REQ-013 Status port err_addr, output, ADDR_W: address of the most recently accepted AW or AR.

Function
REQ-014 The block SHALL act as the bus default responder for unmapped addresses, and every transaction SHALL complete with response code 2'b11 (DECERR).
REQ-015 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP.
REQ-016 In W_IDLE, S_AWReady SHALL be 1, S_WReady SHALL be 0 and S_BValid SHALL be 0.
REQ-017 On AW handshake (S_AWValid&&S_AWReady), the block SHALL latch S_AWID and go to W_DATA; S_WReady SHALL rise in the next cycle.
REQ-018 W beats presented before the AW handshake SHALL be stalled, with S_WReady=0.
REQ-019 In W_DATA, S_WReady SHALL be 1 and S_AWReady SHALL be 0; data SHALL be discarded; beats may be non-contiguous; a handshake with S_WLast=1 SHALL move the FSM to W_RESP.
REQ-020 In W_RESP, S_BValid SHALL be 1, S_BID SHALL equal the latched ID and S_BResp SHALL be 2'b11; these SHALL stay stable until S_BReady; the handshake cycle SHALL return the FSM to W_IDLE.
REQ-021 Read FSM states SHALL be R_IDLE and R_DATA, and the read FSM SHALL be fully independent of the write FSM.
REQ-022 In R_IDLE, S_ARReady SHALL be 1 and S_RValid SHALL be 0; on AR handshake the block SHALL latch S_ARID and S_ARLen, clear the 4-bit beat counter, and go to R_DATA.
REQ-023 In R_DATA, S_ARReady SHALL be 0, S_RValid SHALL be 1, S_RData SHALL be 0, S_RResp SHALL be 2'b11, S_RID SHALL equal the latched ID, and S_RLast SHALL be 1 exactly when counter==latched len; the first beat SHALL be valid in the cycle after the AR handshake.
REQ-024 On each R handshake the counter SHALL increment; the handshake with S_RLast=1 SHALL return the FSM to R_IDLE; exactly ARLen+1 beats SHALL be issued (ARLen=15 -> 16 beats, no counter wrap).
REQ-025 Outputs SHALL hold while S_RValid=1 and S_RReady=0.
REQ-026 err_addr SHALL update on each AW or AR handshake; if both occur in the same cycle, the AR address SHALL win.
REQ-027 err_cnt SHALL increment by 1 on a B handshake or on the R handshake carrying S_RLast, SHALL increment by 2 if both occur in the same cycle, and SHALL saturate at 16'hFFFF.
REQ-028 A new AW or AR SHALL be accepted back-to-back with the prior completion only after a one-cycle return to IDLE; no outstanding depth greater than 1 per direction is supported.

Reset
REQ-029 While ARESETn=0, the block SHALL force W_IDLE and R_IDLE asynchronously and drive S_AWReady=1, S_ARReady=1, S_WReady=0, S_BValid=0, S_RValid=0, S_RLast=0, S_BID=0, S_RID=0, S_BResp=0, S_RResp=0, S_RData=0, err_cnt=0 and err_addr=0.
REQ-030 Reset asserted mid-burst SHALL abandon the transaction, issue no further beats or response, and leave no state latched after deassertion.

Verification
REQ-031 Write, single beat: AW ID=8'h5A, Len=0, then W with WLast=1, BReady=1 -> BValid one cycle later, BID=8'h5A, BResp=2'b11, err_cnt=1.
REQ-032 Read burst with backpressure: AR ID=8'h33, Len=3, RReady toggled 1/0 -> exactly 4 beats, RData=0, RResp=2'b11, RLast on beat 4 only, outputs stable while stalled.
REQ-033 Concurrency: a 16-beat read (Len=15) and a 2-beat write run together, finishing B and the last R handshake in the same cycle -> err_cnt increases by 2; AR address captured in err_addr if AW and AR are accepted in the same cycle.
REQ-034 W-before-AW: WValid asserted 3 cycles ahead of AWValid -> WReady=0 until the cycle after the AW handshake; the write then completes normally.
REQ-035 Reset mid-read: ARESETn pulsed low during beat 2 of a Len=7 read -> RValid=0 immediately, ARReady=1 after release, err_cnt=0.
REQ-036 Saturation: err_cnt preloaded near 16'hFFFF via 65535+ transactions (or forced) -> err_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/axi_default_slave_if.sv
// AXI4 slave-side bundle for the default responder: AW/W/B/AR/R channels.
// The slave modport is the responder view; master is the requester view.
interface axi_default_slave_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic [ID_W-1:0]     S_AWID;
    logic [ADDR_W-1:0]   S_AWAddr;
    logic [LEN_W-1:0]    S_AWLen;
    logic [2:0]          S_AWSize;
    logic [1:0]          S_AWBurst;
    logic                S_AWValid;
    logic                S_AWReady;

    logic [DATA_W-1:0]   S_WData;
    logic [DATA_W/8-1:0] S_WStrb;
    logic                S_WLast;
    logic                S_WValid;
    logic                S_WReady;

    logic [ID_W-1:0]     S_BID;
    logic [1:0]          S_BResp;
    logic                S_BValid;
    logic                S_BReady;

    logic [ID_W-1:0]     S_ARID;
    logic [ADDR_W-1:0]   S_ARAddr;
    logic [LEN_W-1:0]    S_ARLen;
    logic [2:0]          S_ARSize;
    logic [1:0]          S_ARBurst;
    logic                S_ARValid;
    logic                S_ARReady;

    logic [ID_W-1:0]     S_RID;
    logic [DATA_W-1:0]   S_RData;
    logic [1:0]          S_RResp;
    logic                S_RLast;
    logic                S_RValid;
    logic                S_RReady;

    modport slave (
        input  S_AWID, S_AWAddr, S_AWLen, S_AWSize, S_AWBurst, S_AWValid,
        output S_AWReady,
        input  S_WData, S_WStrb, S_WLast, S_WValid,
        output S_WReady,
        output S_BID, S_BResp, S_BValid,
        input  S_BReady,
        input  S_ARID, S_ARAddr, S_ARLen, S_ARSize, S_ARBurst, S_ARValid,
        output S_ARReady,
        output S_RID, S_RData, S_RResp, S_RLast, S_RValid,
        input  S_RReady
    );

    modport master (
        output S_AWID, S_AWAddr, S_AWLen, S_AWSize, S_AWBurst, S_AWValid,
        input  S_AWReady,
        output S_WData, S_WStrb, S_WLast, S_WValid,
        input  S_WReady,
        input  S_BID, S_BResp, S_BValid,
        output S_BReady,
        output S_ARID, S_ARAddr, S_ARLen, S_ARSize, S_ARBurst, S_ARValid,
        input  S_ARReady,
        input  S_RID, S_RData, S_RResp, S_RLast, S_RValid,
        output S_RReady
    );
endinterface

// File: rtl/axi_default_slave.sv
// Default AXI responder for unmapped space: every write and read ends in DECERR.
// Independent write/read FSMs, one outstanding transaction per direction.
//
//   state  | meaning
//   W_IDLE | waiting for AW, W stalled
//   W_DATA | swallowing W beats until WLast
//   W_RESP | presenting B (DECERR) until BReady
//   R_IDLE | waiting for AR
//   R_DATA | issuing ARLen+1 zero-data DECERR beats
module axi_default_slave #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    axi_default_slave_if.slave  s,
    output logic [15:0]         err_cnt,
    output logic [ADDR_W-1:0]   err_addr
);
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic [ID_W-1:0]   ar_id_q, ar_id_d;
    logic [LEN_W-1:0]  ar_len_q, ar_len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic aw_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign aw_hs     = (w_state_q == W_IDLE) && s.S_AWValid;
    assign w_last_hs = (w_state_q == W_DATA) && s.S_WValid && s.S_WLast;
    assign b_hs      = (w_state_q == W_RESP) && s.S_BReady;
    assign ar_hs     = (r_state_q == R_IDLE) && s.S_ARValid;
    assign r_hs      = (r_state_q == R_DATA) && s.S_RReady;
    assign r_last    = (r_state_q == R_DATA) && (beat_q == ar_len_q);

    // ---------------- write FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) w_state_q <= W_IDLE;
        else          w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs)     w_state_d = W_DATA;
            W_DATA:  if (w_last_hs) w_state_d = W_RESP;
            W_RESP:  if (b_hs)      w_state_d = W_IDLE;
            default:                w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        s.S_AWReady = 1'b0;
        s.S_WReady  = 1'b0;
        s.S_BValid  = 1'b0;
        s.S_BID     = '0;
        s.S_BResp   = 2'b00;
        case (w_state_q)
            W_IDLE: s.S_AWReady = 1'b1;
            W_DATA: s.S_WReady  = 1'b1;
            W_RESP: begin
                s.S_BValid = 1'b1;
                s.S_BID    = aw_id_q;
                s.S_BResp  = RESP_DECERR;
            end
            default: s.S_AWReady = 1'b0;
        endcase
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state_q <= R_IDLE;
        else          r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)           r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_last)  r_state_d = R_IDLE;
            default:                      r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s.S_ARReady = 1'b0;
        s.S_RValid  = 1'b0;
        s.S_RID     = '0;
        s.S_RResp   = 2'b00;
        s.S_RLast   = 1'b0;
        s.S_RData   = {DATA_W{1'b0}};
        case (r_state_q)
            R_IDLE: s.S_ARReady = 1'b1;
            R_DATA: begin
                s.S_RValid = 1'b1;
                s.S_RID    = ar_id_q;
                s.S_RResp  = RESP_DECERR;
                s.S_RLast  = r_last;
            end
            default: s.S_ARReady = 1'b0;
        endcase
    end

    // ---------------- latched context and status ----------------
    assign aw_id_d  = aw_hs ? s.S_AWID  : aw_id_q;
    assign ar_id_d  = ar_hs ? s.S_ARID  : ar_id_q;
    assign ar_len_d = ar_hs ? s.S_ARLen : ar_len_q;
    // The counter never needs to wrap: the RLast beat leaves R_DATA.
    assign beat_d   = ar_hs ? '0 : (r_hs ? beat_q + LEN_W'(1) : beat_q);

    // AR address takes priority when both address channels fire together.
    assign err_addr_d = ar_hs ? s.S_ARAddr : (aw_hs ? s.S_AWAddr : err_addr_q);

    assign err_inc   = {1'b0, b_hs} + {1'b0, r_hs && r_last};
    assign err_sum   = {1'b0, err_cnt_q} + {15'b0, err_inc};
    assign err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_id_q    <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= '0;
            beat_q     <= '0;
            err_cnt_q  <= 16'h0000;
            err_addr_q <= '0;
        end else begin
            aw_id_q    <= aw_id_d;
            ar_id_q    <= ar_id_d;
            ar_len_q   <= ar_len_d;
            beat_q     <= beat_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

    logic unused_bus;
    assign unused_bus = ^{s.S_AWLen, s.S_AWSize, s.S_AWBurst, s.S_WData, s.S_WStrb,
                          s.S_ARSize, s.S_ARBurst};
endmodule

// File: tb/tb_axi_default_slave.sv
// Directed bench for axi_default_slave: write/read DECERR paths, backpressure,
// concurrency, W-before-AW, mid-burst reset and error-counter saturation.
module tb_axi_default_slave;
    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic [15:0] err_cnt;
    logic [31:0] err_addr;

    int n_cmp = 0;
    int n_err = 0;

    axi_default_slave_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

    axi_default_slave #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .s        (bus),
        .err_cnt  (err_cnt),
        .err_addr (err_addr)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.S_AWID = '0; bus.S_AWAddr = '0; bus.S_AWLen = '0; bus.S_AWSize = 3'd2;
        bus.S_AWBurst = 2'b01; bus.S_AWValid = 1'b0;
        bus.S_WData = 32'hDEAD_BEEF; bus.S_WStrb = 4'hF; bus.S_WLast = 1'b0; bus.S_WValid = 1'b0;
        bus.S_BReady = 1'b0;
        bus.S_ARID = '0; bus.S_ARAddr = '0; bus.S_ARLen = '0; bus.S_ARSize = 3'd2;
        bus.S_ARBurst = 2'b01; bus.S_ARValid = 1'b0;
        bus.S_RReady = 1'b0;
    endtask

    initial begin
        int hs;
        logic rr;
        logic done;

        idle_inputs();
        #1 ARESETn = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        // ---- reset values
        chk("rst_awready", bus.S_AWReady, 1);
        chk("rst_arready", bus.S_ARReady, 1);
        chk("rst_wready",  bus.S_WReady,  0);
        chk("rst_bvalid",  bus.S_BValid,  0);
        chk("rst_rvalid",  bus.S_RValid,  0);
        chk("rst_rlast",   bus.S_RLast,   0);
        chk("rst_bid",     bus.S_BID,     0);
        chk("rst_rid",     bus.S_RID,     0);
        chk("rst_bresp",   bus.S_BResp,   0);
        chk("rst_rresp",   bus.S_RResp,   0);
        chk("rst_rdata",   bus.S_RData,   0);
        chk("rst_errcnt",  err_cnt,       0);
        chk("rst_erraddr", err_addr,      0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // ---- single-beat write
        bus.S_AWID = 8'h5A; bus.S_AWAddr = 32'h1000_0000; bus.S_AWLen = 4'd0; bus.S_AWValid = 1'b1;
        bus.S_WValid = 1'b1; bus.S_WLast = 1'b1; bus.S_BReady = 1'b1;
        chk("wr1_wready_idle", bus.S_WReady, 0);
        @(negedge ACLK);
        chk("wr1_awready_data", bus.S_AWReady, 0);
        chk("wr1_wready_data",  bus.S_WReady,  1);
        chk("wr1_erraddr",      err_addr,      32'h1000_0000);
        bus.S_AWValid = 1'b0;
        @(negedge ACLK);
        chk("wr1_bvalid", bus.S_BValid, 1);
        chk("wr1_bid",    bus.S_BID,    8'h5A);
        chk("wr1_bresp",  bus.S_BResp,  2'b11);
        chk("wr1_wready_resp", bus.S_WReady, 0);
        bus.S_WValid = 1'b0; bus.S_WLast = 1'b0;
        @(negedge ACLK);
        chk("wr1_bvalid_done", bus.S_BValid, 0);
        chk("wr1_awready_done", bus.S_AWReady, 1);
        chk("wr1_errcnt", err_cnt, 1);
        bus.S_BReady = 1'b0;

        // ---- 4-beat read with RReady toggling
        bus.S_ARID = 8'h33; bus.S_ARAddr = 32'h2000_0040; bus.S_ARLen = 4'd3; bus.S_ARValid = 1'b1;
        bus.S_RReady = 1'b0;
        @(negedge ACLK);
        bus.S_ARValid = 1'b0;
        chk("rd_arready_busy", bus.S_ARReady, 0);
        chk("rd_erraddr", err_addr, 32'h2000_0040);
        hs = 0; rr = 1'b1; done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (k > 0) @(negedge ACLK);
            chk("rd_rvalid", bus.S_RValid, 1);
            chk("rd_rlast",  bus.S_RLast,  (hs == 3) ? 1 : 0);
            chk("rd_rid",    bus.S_RID,    8'h33);
            chk("rd_rdata",  bus.S_RData,  0);
            chk("rd_rresp",  bus.S_RResp,  2'b11);
            bus.S_RReady = rr;
            if (rr) begin
                hs++;
                if (hs == 4) done = 1'b1;
            end
            rr = ~rr;
        end
        @(negedge ACLK);
        chk("rd_beats", hs, 4);
        chk("rd_rvalid_done", bus.S_RValid, 0);
        chk("rd_arready_done", bus.S_ARReady, 1);
        chk("rd_errcnt", err_cnt, 2);
        bus.S_RReady = 1'b0;

        // ---- W presented 3 cycles before AW, B held off for two cycles
        bus.S_WValid = 1'b1; bus.S_WLast = 1'b1; bus.S_BReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            chk("wb4aw_wready_stall", bus.S_WReady, 0);
        end
        bus.S_AWID = 8'h77; bus.S_AWAddr = 32'h3000_0000; bus.S_AWValid = 1'b1;
        @(negedge ACLK);
        chk("wb4aw_wready", bus.S_WReady, 1);
        bus.S_AWValid = 1'b0;
        @(negedge ACLK);
        chk("wb4aw_bvalid", bus.S_BValid, 1);
        chk("wb4aw_bid",    bus.S_BID,    8'h77);
        bus.S_WValid = 1'b0; bus.S_WLast = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge ACLK);
            chk("wb4aw_bvalid_hold", bus.S_BValid, 1);
            chk("wb4aw_bid_hold",    bus.S_BID,    8'h77);
            chk("wb4aw_bresp_hold",  bus.S_BResp,  2'b11);
        end
        bus.S_BReady = 1'b1;
        @(negedge ACLK);
        chk("wb4aw_bvalid_done", bus.S_BValid, 0);
        chk("wb4aw_errcnt", err_cnt, 3);
        bus.S_BReady = 1'b0;

        // ---- 16-beat read alongside a 2-beat write, B and last R together
        bus.S_AWID = 8'h11; bus.S_AWAddr = 32'hAAAA_0000; bus.S_AWValid = 1'b1;
        bus.S_ARID = 8'h22; bus.S_ARAddr = 32'hBBBB_0000; bus.S_ARLen = 4'd15; bus.S_ARValid = 1'b1;
        bus.S_RReady = 1'b1;
        @(negedge ACLK);
        chk("cc_erraddr_ar_wins", err_addr, 32'hBBBB_0000);
        bus.S_AWValid = 1'b0; bus.S_ARValid = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            if (cyc > 1) @(negedge ACLK);
            chk("cc_rvalid", bus.S_RValid, 1);
            chk("cc_rlast",  bus.S_RLast,  (cyc == 16) ? 1 : 0);
            chk("cc_wready", bus.S_WReady, (cyc <= 5) ? 1 : 0);
            chk("cc_bvalid", bus.S_BValid, (cyc >= 6) ? 1 : 0);
            case (cyc)
                1: begin bus.S_WValid = 1'b1; bus.S_WLast = 1'b0; end
                2: bus.S_WValid = 1'b0;
                5: begin bus.S_WValid = 1'b1; bus.S_WLast = 1'b1; end
                6: begin bus.S_WValid = 1'b0; bus.S_WLast = 1'b0; end
                16: bus.S_BReady = 1'b1;
                default: ;
            endcase
        end
        chk("cc_bid", bus.S_BID, 8'h11);
        chk("cc_rid", bus.S_RID, 8'h22);
        @(negedge ACLK);
        chk("cc_errcnt_plus2", err_cnt, 5);
        chk("cc_rvalid_done",  bus.S_RValid, 0);
        chk("cc_bvalid_done",  bus.S_BValid, 0);
        bus.S_RReady = 1'b0; bus.S_BReady = 1'b0;

        // ---- reset during beat 2 of an 8-beat read
        bus.S_ARID = 8'h44; bus.S_ARAddr = 32'h0000_1230; bus.S_ARLen = 4'd7; bus.S_ARValid = 1'b1;
        bus.S_RReady = 1'b1;
        @(negedge ACLK);
        bus.S_ARValid = 1'b0;
        @(negedge ACLK);
        chk("mrst_rvalid_beat2", bus.S_RValid, 1);
        #2 ARESETn = 1'b0;
        #1;
        chk("mrst_rvalid_now",  bus.S_RValid,  0);
        chk("mrst_arready_now", bus.S_ARReady, 1);
        chk("mrst_errcnt_now",  err_cnt,       0);
        chk("mrst_rid_now",     bus.S_RID,     0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge ACLK);
            chk("mrst_rvalid_after",  bus.S_RValid,  0);
            chk("mrst_arready_after", bus.S_ARReady, 1);
            chk("mrst_errcnt_after",  err_cnt,       0);
            chk("mrst_erraddr_after", err_addr,      0);
        end
        bus.S_RReady = 1'b0;

        // ---- saturation: preload near the top, then +2 and +1
        force dut.err_cnt_q = 16'hFFFE;
        @(negedge ACLK);
        release dut.err_cnt_q;
        @(negedge ACLK);
        chk("sat_preload", err_cnt, 16'hFFFE);
        bus.S_AWID = 8'h01; bus.S_AWAddr = 32'h4000_0000; bus.S_AWValid = 1'b1;
        bus.S_ARID = 8'h02; bus.S_ARAddr = 32'h5000_0000; bus.S_ARLen = 4'd0; bus.S_ARValid = 1'b1;
        bus.S_WValid = 1'b1; bus.S_WLast = 1'b1; bus.S_BReady = 1'b1; bus.S_RReady = 1'b0;
        @(negedge ACLK);
        bus.S_AWValid = 1'b0; bus.S_ARValid = 1'b0;
        chk("sat_erraddr", err_addr, 32'h5000_0000);
        @(negedge ACLK);
        chk("sat_bvalid", bus.S_BValid, 1);
        chk("sat_rlast",  bus.S_RLast,  1);
        bus.S_WValid = 1'b0; bus.S_WLast = 1'b0; bus.S_RReady = 1'b1;
        @(negedge ACLK);
        chk("sat_errcnt_plus2", err_cnt, 16'hFFFF);
        chk("sat_rvalid_done",  bus.S_RValid, 0);
        bus.S_RReady = 1'b0;
        bus.S_AWID = 8'h03; bus.S_AWAddr = 32'h6000_0000; bus.S_AWValid = 1'b1;
        bus.S_WValid = 1'b1; bus.S_WLast = 1'b1;
        @(negedge ACLK);
        bus.S_AWValid = 1'b0;
        @(negedge ACLK);
        chk("sat_bvalid2", bus.S_BValid, 1);
        bus.S_WValid = 1'b0; bus.S_WLast = 1'b0;
        @(negedge ACLK);
        chk("sat_errcnt_hold", err_cnt, 16'hFFFF);
        chk("sat_bvalid2_done", bus.S_BValid, 0);
        bus.S_BReady = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
